// File: rtl/cpu_bus_arbiter_if.sv
// rtl/cpu_bus_arbiter_if.sv - request/ack and peripheral bus signal bundle for cpu_bus_arbiter
interface cpu_bus_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          ce;
  logic          rd;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_wr;
  logic [DW-1:0] data_rd;
  logic          busy;
  logic [1:0]    grant;

  // Arbiter view: serves the two requesters and drives the peripheral bus.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, data_rd,
    output ack0, ack1, rdata0, rdata1, ce, rd, wr, addr, data_wr, busy, grant
  );

  // Environment view: requesting engines plus the bus-attached slave.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, data_rd,
    input  ack0, ack1, rdata0, rdata1, ce, rd, wr, addr, data_wr, busy, grant
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - two-master arbiter/sequencer for the 8-bit CPU peripheral bus (option: BUS_ARB_FIXED_PRIO_EN)
module cpu_bus_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_bus_arbiter_if.slave bus
);

  localparam int CW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_win;      // 0 = master 0 owns the transaction, 1 = master 1
  logic          r_we_l;
  logic [CW-1:0] r_cnt;
  logic          r_ce;
  logic          r_rd;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data_wr;
  logic          r_ack0;
  logic          r_ack1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_busy;
  logic [1:0]    r_grant;

  logic          w_win;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

`ifdef BUS_ARB_FIXED_PRIO_EN
  // Fixed priority: master 1 only wins when master 0 is not requesting.
  always_comb begin
    w_win = ~bus.req0;
  end
`else
  logic r_last_grant;

  // Round-robin: on a tie the master not granted last wins.
  always_comb begin
    w_win = ~bus.req0;
    if (bus.req0 && bus.req1) begin
      w_win = ~r_last_grant;
    end
  end

  // Remember the most recent winner for the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (r_state == S_IDLE && (bus.req0 || bus.req1)) begin
      r_last_grant <= w_win;
    end
  end
`endif

  // Mux the winning master's request fields.
  always_comb begin
    w_sel_we    = w_win ? bus.we1    : bus.we0;
    w_sel_addr  = w_win ? bus.addr1  : bus.addr0;
    w_sel_wdata = w_win ? bus.wdata1 : bus.wdata0;
  end

  // Transaction sequencer: grant in IDLE, strobe the bus in ACCESS, acknowledge in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_win     <= 1'b0;
      r_we_l    <= 1'b0;
      r_cnt     <= '0;
      r_ce      <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_data_wr <= '0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_busy    <= 1'b0;
      r_grant   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_win     <= w_win;
            r_we_l    <= w_sel_we;
            r_cnt     <= CW'(WAIT_CYC);
            r_ce      <= 1'b1;
            r_rd      <= ~w_sel_we;
            r_wr      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_data_wr <= w_sel_we ? w_sel_wdata : '0;
            r_busy    <= 1'b1;
            r_grant   <= w_win ? 2'b10 : 2'b01;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            // Slave returns data_rd combinationally while ce & rd, so sample it on the last access edge.
            if (!r_we_l) begin
              if (r_win) begin
                r_rdata1 <= bus.data_rd;
              end else begin
                r_rdata0 <= bus.data_rd;
              end
            end
            r_ce      <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_data_wr <= '0;
            r_ack0    <= ~r_win;
            r_ack1    <= r_win;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_grant <= 2'b00;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ce      = r_ce;
  assign bus.rd      = r_rd;
  assign bus.wr      = r_wr;
  assign bus.addr    = r_addr;
  assign bus.data_wr = r_data_wr;
  assign bus.ack0    = r_ack0;
  assign bus.ack1    = r_ack1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;
  assign bus.busy    = r_busy;
  assign bus.grant   = r_grant;

endmodule
